rmii_frame_arbiter: RTL
=======================

// Module: rmii_frame_arbiter
// PURPOSE
// - N-channel, frame-granular round-robin arbiter between N FRAME_FIFO read ports and one RMII_TX.
// - Generalises the fixed 1:1 FIFO-to-TX wiring of the 2-port repeater to N-port hub/flood
//   forwarding; one instance per egress PHY, all FIFO read sides clocked by that PHY's REF_CLK.
// - Never interleaves frames; inserts a programmable gap between frames; counts frames per channel.
// PARAMETERS
// - N_CH        4    number of ingress channels (2..8)
// - GAP_CYCLES  48   idle REF_CLK cycles enforced after each frame (>=1)
// - STARVE_CYC  256  cycles a non-empty but aempty channel waits before it becomes eligible
// - CNT_W       16   width of per-channel frame counters
// PORTS
// - REF_CLK         in   1          sole clock (egress PHY reference clock, 50 MHz)
// - arst_n          in   1          asynchronous active-low reset
// - ch_en           in   N_CH       per-channel enable mask
// - ch_empty        in   N_CH       FIFO empty_flag per channel
// - ch_aempty       in   N_CH       FIFO aempty_flag per channel
// - ch_dout         in   8*N_CH     FIFO do per channel, channel i at [8i+7:8i]
// - ch_eod          in   N_CH       FIFO EOD_out per channel, aligned with ch_dout
// - ch_rden         out  N_CH       FIFO re per channel
// - tx_empty        out  1          to RMII_TX fifo_empty
// - tx_aempty       out  1          to RMII_TX fifo_aempty
// - tx_dout         out  8          to RMII_TX fifo_dout
// - tx_eod          out  1          to RMII_TX fifo_EOD_out
// - tx_rden         in   1          from RMII_TX fifo_rden
// - grant_vld       out  1          a channel currently owns the TX path
// - grant_idx       out  $clog2(N_CH)  owning channel
// - frame_cnt       out  CNT_W*N_CH frames forwarded per channel, wrap-around
// BEHAVIOUR
// - Reset (async, any time incl. mid-frame): state IDLE, ch_rden=0, tx_empty=1, tx_aempty=1,
//   tx_dout=0, tx_eod=0, grant_vld=0, grant_idx=0, RR pointer=0, starve counters=0, frame_cnt=0.
// - FIFO read latency 1: data/EOD valid the cycle after re; arbiter adds no latency on data.
// - Eligible(i) = ch_en[i] & ~ch_empty[i] & (~ch_aempty[i] | starve_cnt[i]==STARVE_CYC).
//   starve_cnt[i] counts while ch_en & ~ch_empty & ch_aempty; clears otherwise; saturates.
// - States: IDLE -> (any eligible) GRANT; GRANT -> (tx_eod sampled high with a read) GAP;
//   GAP -> (gap counter == GAP_CYCLES-1) IDLE.
// - IDLE: pick first eligible channel at or after RR pointer (wrapping N_CH-1 -> 0); register
//   grant_idx, grant_vld=1 next cycle. RR pointer = grant_idx+1 (mod N_CH) at grant.
// - GRANT: combinational pass-through: ch_rden[g]=tx_rden, others 0; tx_dout/tx_eod/tx_empty/
//   tx_aempty = channel g. No read is passed when ch_empty[g]=1 (ch_rden[g]=tx_rden&~ch_empty[g]).
// - Frame end: cycle after a passed read where ch_eod[g]=1. frame_cnt[g]++, go GAP.
// - IDLE/GAP: tx_empty=1, tx_aempty=1, tx_eod=0, all ch_rden=0; tx_dout holds 0.
// - ch_en[g] deasserted mid-frame: ignored until frame end (no truncation); channel then ineligible.
// - Simultaneous eligibility: RR order decides; a channel cannot win twice while another waits.
// - frame_cnt wraps 2^CNT_W-1 -> 0, no saturation.
// STRUCTURE
// - Shared package rmii_pkg: state enum (IDLE/GRANT/GAP), DATA_W=8, helper for $clog2 index width.
// - One sub-module: rr_picker (N_CH request vector + pointer -> one-hot/index, combinational).
// - Top holds FSM, gap counter, starve counters, frame counters, output muxes.
// TESTING
// - Reset: arst_n low mid-frame on ch1 -> all outputs at reset values same cycle; no ch_rden pulse.
// - Single frame: ch0 100 bytes, EOD on last -> 100 bytes on tx_dout in order, ch_rden only ch0,
//   frame_cnt[0]=1, tx_empty=1 for exactly 48 cycles after EOD.
// - Round robin: ch0..3 each hold 3 frames of 80 bytes -> grant sequence 0,1,2,3,0,1,2,3,...,
//   every frame_cnt=3, no byte interleaving.
// - Starvation: ch2 holds one 20-byte frame (aempty stays 1) -> granted after 256 cycles, not before.
// - Disable: ch_en[1]=0 while ch1 is granted -> frame completes; ch1 then never granted; ch_en[1]=0
//   with data pending and no grant -> ch1 skipped, frame_cnt[1] unchanged.
// - Underrun: ch_empty[g]=1 mid-frame with tx_rden=1 -> ch_rden[g]=0, tx_empty=1, grant held.

Source files
------------

// File: rtl/rmii_frame_arbiter_pkg.sv
// Shared types and helpers for the RMII frame arbiter.
package rmii_frame_arbiter_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } arb_state_e;

  // Width of an index into n items; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rmii_frame_arbiter_if.sv
// FIFO read ports of all ingress channels plus the single RMII_TX read port.
interface rmii_frame_arbiter_if #(
  parameter int N_CH = 4
);
  import rmii_frame_arbiter_pkg::*;

  logic [N_CH-1:0]        ch_en;
  logic [N_CH-1:0]        ch_empty;
  logic [N_CH-1:0]        ch_aempty;
  logic [DATA_W*N_CH-1:0] ch_dout;
  logic [N_CH-1:0]        ch_eod;
  logic [N_CH-1:0]        ch_rden;

  logic                   tx_empty;
  logic                   tx_aempty;
  logic [DATA_W-1:0]      tx_dout;
  logic                   tx_eod;
  logic                   tx_rden;

  // Arbiter side
  modport master (
    input  ch_en, ch_empty, ch_aempty, ch_dout, ch_eod, tx_rden,
    output ch_rden, tx_empty, tx_aempty, tx_dout, tx_eod
  );

  // FIFO / transmitter side
  modport slave (
    output ch_en, ch_empty, ch_aempty, ch_dout, ch_eod, tx_rden,
    input  ch_rden, tx_empty, tx_aempty, tx_dout, tx_eod
  );

endinterface

// File: rtl/rmii_frame_arbiter_rr_picker.sv
// Round-robin picker: first requester at or after ptr, wrapping at N_CH-1.
module rr_picker
  import rmii_frame_arbiter_pkg::*;
#(
  parameter  int N_CH = 4,
  localparam int IW   = idx_w(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic            found,
  output logic [IW-1:0]   idx
);

  logic [IW:0] pos;

  // Scan every position once starting at ptr and keep the first requester.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    pos   = '0;
    for (int k = 0; k < N_CH; k++) begin
      pos = {1'b0, ptr} + (IW+1)'(k);
      if (pos >= (IW+1)'(N_CH)) pos = pos - (IW+1)'(N_CH);
      if (!found && req[pos[IW-1:0]]) begin
        found = 1'b1;
        idx   = pos[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/rmii_frame_arbiter.sv
// Frame-granular round-robin arbiter from N FIFO read ports onto one RMII_TX.
// Whole frames only, a fixed idle gap after each, per-channel frame counters.
module rmii_frame_arbiter
  import rmii_frame_arbiter_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int GAP_CYCLES = 48,
  parameter int STARVE_CYC = 256,
  parameter int CNT_W      = 16
) (
  input  logic                      REF_CLK,
  input  logic                      arst_n,
  rmii_frame_arbiter_if.master      bus,
  output logic                      grant_vld,
  output logic [idx_w(N_CH)-1:0]    grant_idx,
  output logic [CNT_W*N_CH-1:0]     frame_cnt
);

  localparam int IW = idx_w(N_CH);
  localparam int SW = $clog2(STARVE_CYC + 1);
  localparam int GW = idx_w(GAP_CYCLES);

  arb_state_e        state, state_nxt;
  logic [IW-1:0]     rr_ptr;
  logic [SW-1:0]     starve_cnt [N_CH];
  logic [CNT_W-1:0]  cnt        [N_CH];
  logic [DATA_W-1:0] dout_a     [N_CH];
  logic [GW-1:0]     gap_cnt;
  logic              rd_pend;
  logic [N_CH-1:0]   eligible;
  logic              pick_found;
  logic [IW-1:0]     pick_idx;
  logic [DATA_W-1:0] g_dout;
  logic              g_empty, g_aempty, g_eod;
  logic              frame_end;

  // Unpack channel data and work out which channels may compete this cycle.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      dout_a[i]   = bus.ch_dout[i*DATA_W +: DATA_W];
      eligible[i] = bus.ch_en[i] & ~bus.ch_empty[i] &
                    (~bus.ch_aempty[i] | (starve_cnt[i] == SW'(STARVE_CYC)));
    end
  end

  rr_picker #(.N_CH(N_CH)) u_picker (
    .req   (eligible),
    .ptr   (rr_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign g_dout   = dout_a[grant_idx];
  assign g_empty  = bus.ch_empty[grant_idx];
  assign g_aempty = bus.ch_aempty[grant_idx];
  assign g_eod    = bus.ch_eod[grant_idx];

  // The byte delivered this cycle came from a passed read and carries EOD.
  assign frame_end = (state == ST_GRANT) && rd_pend && g_eod;

  // Next state and the TX-side mux; TX looks empty whenever nobody owns it.
  always_comb begin
    state_nxt     = state;
    bus.ch_rden   = '0;
    bus.tx_empty  = 1'b1;
    bus.tx_aempty = 1'b1;
    bus.tx_dout   = '0;
    bus.tx_eod    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pick_found) state_nxt = ST_GRANT;
      end
      ST_GRANT: begin
        bus.tx_empty  = g_empty;
        bus.tx_aempty = g_aempty;
        bus.tx_dout   = g_dout;
        bus.tx_eod    = g_eod;
        // On the EOD byte no further read is passed, so the next frame
        // of this channel stays in its FIFO until it wins again.
        if (frame_end) state_nxt = ST_GAP;
        else           bus.ch_rden[grant_idx] = bus.tx_rden & ~g_empty;
      end
      ST_GAP: begin
        if (gap_cnt == GW'(GAP_CYCLES - 1)) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register, grant ownership and round-robin pointer.
  always_ff @(posedge REF_CLK or negedge arst_n) begin
    if (!arst_n) begin
      state     <= ST_IDLE;
      grant_vld <= 1'b0;
      grant_idx <= '0;
      rr_ptr    <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && pick_found) begin
        grant_vld <= 1'b1;
        grant_idx <= pick_idx;
        rr_ptr    <= (pick_idx == IW'(N_CH - 1)) ? '0 : pick_idx + 1'b1;
      end else if (frame_end) begin
        grant_vld <= 1'b0;
      end
    end
  end

  // Remember whether a read was passed, so the next cycle knows its data is real.
  always_ff @(posedge REF_CLK or negedge arst_n) begin
    if (!arst_n) rd_pend <= 1'b0;
    else         rd_pend <= |bus.ch_rden;
  end

  // Inter-frame gap counter, only runs in GAP.
  always_ff @(posedge REF_CLK or negedge arst_n) begin
    if (!arst_n) begin
      gap_cnt <= '0;
    end else if (state == ST_GAP) begin
      gap_cnt <= (gap_cnt == GW'(GAP_CYCLES - 1)) ? '0 : gap_cnt + 1'b1;
    end else begin
      gap_cnt <= '0;
    end
  end

  // Starvation counters: age a pending-but-almost-empty channel, saturating.
  always_ff @(posedge REF_CLK or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < N_CH; i++) starve_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (bus.ch_en[i] & ~bus.ch_empty[i] & bus.ch_aempty[i]) begin
          if (starve_cnt[i] != SW'(STARVE_CYC)) starve_cnt[i] <= starve_cnt[i] + 1'b1;
        end else begin
          starve_cnt[i] <= '0;
        end
      end
    end
  end

  // Per-channel frame counters, wrap-around.
  always_ff @(posedge REF_CLK or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < N_CH; i++) cnt[i] <= '0;
    end else if (frame_end) begin
      cnt[grant_idx] <= cnt[grant_idx] + 1'b1;
    end
  end

  // Flatten the counters onto the output bus.
  always_comb begin
    frame_cnt = '0;
    for (int i = 0; i < N_CH; i++) frame_cnt[i*CNT_W +: CNT_W] = cnt[i];
  end

endmodule
